// File: rtl/carfield_region_err_slv.sv
// Default AXI4 subordinate for the Carfield host address map.
// Classifies addresses against the region table for the crossbar and
// terminates every transaction routed here with an error response.
module carfield_region_err_slv #(
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned IdWidth    = 4,
    parameter int unsigned DataWidth  = 64,
    parameter int unsigned NumRegions = 8,
    parameter logic [NumRegions-1:0] RegionEnable = 8'b1001_0011,
    parameter logic [AddrWidth-1:0]  RegionBase [NumRegions] = '{
        64'h7800_0000, 64'h7820_0000, 64'h6000_0000, 64'h2000_0000,
        64'h2000_1000, 64'h5100_0000, 64'h5000_0000, 64'h4000_0000},
    parameter logic [AddrWidth-1:0]  RegionSize [NumRegions] = '{
        64'h20_0000, 64'h20_0000, 64'h80_0000, 64'h1000,
        64'h9000,    64'h80_0000, 64'h80_0000, 64'h1000}
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] dec_addr_i,
    output logic [2:0]           dec_idx_o,
    output logic                 dec_hit_o,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [AddrWidth-1:0] aw_addr_i,
    input  logic [7:0]           aw_len_i,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [1:0]           b_resp_o,
    output logic [IdWidth-1:0]   b_id_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [AddrWidth-1:0] ar_addr_i,
    input  logic [7:0]           ar_len_i,
    input  logic [IdWidth-1:0]   ar_id_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o,
    output logic [IdWidth-1:0]   r_id_o
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic       {R_IDLE = 1'b0, R_BEATS = 1'b1} r_state_e;

    // One extra bit keeps base + size from overflowing at the top of the map.
    function automatic logic in_region(input logic [AddrWidth-1:0] addr, input int idx);
        logic [AddrWidth:0] lo;
        logic [AddrWidth:0] hi;
        logic [AddrWidth:0] a;
        lo = {1'b0, RegionBase[idx]};
        hi = lo + {1'b0, RegionSize[idx]};
        a  = {1'b0, addr};
        return (RegionSize[idx] != {AddrWidth{1'b0}}) && (a >= lo) && (a < hi);
    endfunction

    // Hitting a region that exists but is switched off is a slave error;
    // anything else routed here is a decode error.
    function automatic logic [1:0] err_resp(input logic [AddrWidth-1:0] addr);
        logic dis_hit;
        dis_hit = 1'b0;
        for (int i = 0; i < int'(NumRegions); i++) begin
            dis_hit = dis_hit | (!RegionEnable[i] && in_region(addr, i));
        end
        return dis_hit ? 2'b10 : 2'b11;
    endfunction

    logic           dec_hit_s;
    logic [2:0]     dec_idx_s;
    logic           aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;

    w_state_e       w_state_q, w_state_d;
    logic           aw_ready_q, aw_ready_d;
    logic           w_ready_q, w_ready_d;
    logic           b_valid_q, b_valid_d;
    logic [1:0]     b_resp_q, b_resp_d;
    logic [IdWidth-1:0] b_id_q, b_id_d;

    r_state_e       r_state_q, r_state_d;
    logic           ar_ready_q, ar_ready_d;
    logic           r_valid_q, r_valid_d;
    logic           r_last_q, r_last_d;
    logic [1:0]     r_resp_q, r_resp_d;
    logic [IdWidth-1:0] r_id_q, r_id_d;
    logic [7:0]     cnt_q, cnt_d;

    // Decoder: lowest enabled matching region wins.
    always_comb begin
        dec_hit_s = 1'b0;
        dec_idx_s = 3'd0;
        for (int i = 0; i < int'(NumRegions); i++) begin
            dec_idx_s = (!dec_hit_s && RegionEnable[i] && in_region(dec_addr_i, i)) ? 3'(i) : dec_idx_s;
            dec_hit_s = dec_hit_s | (RegionEnable[i] && in_region(dec_addr_i, i));
        end
    end

    assign dec_hit_o = dec_hit_s;
    assign dec_idx_o = dec_idx_s;

    assign aw_hs_s = aw_valid_i && aw_ready_q;
    assign w_hs_s  = w_valid_i  && w_ready_q;
    assign b_hs_s  = b_valid_q  && b_ready_i;
    assign ar_hs_s = ar_valid_i && ar_ready_q;
    assign r_hs_s  = r_valid_q  && r_ready_i;

    // Write FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    // Write FSM next state; w_last is the only end-of-burst indication used.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs_s) w_state_d = W_DATA; else w_state_d = W_IDLE;
            W_DATA:  if (w_hs_s && w_last_i) w_state_d = W_RESP; else w_state_d = W_DATA;
            W_RESP:  if (b_hs_s) w_state_d = W_IDLE; else w_state_d = W_RESP;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write outputs derived from the next state so they come straight from flops.
    always_comb begin
        aw_ready_d = (w_state_d == W_IDLE);
        w_ready_d  = (w_state_d == W_DATA);
        b_valid_d  = (w_state_d == W_RESP);
        if (aw_hs_s) begin
            b_id_d   = aw_id_i;
            b_resp_d = err_resp(aw_addr_i);
        end else begin
            b_id_d   = b_id_q;
            b_resp_d = b_resp_q;
        end
    end

    // Write output registers; all deasserted while in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= {IdWidth{1'b0}};
            b_resp_q   <= 2'b00;
        end else begin
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            b_resp_q   <= b_resp_d;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    // Read FSM next state.
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs_s) r_state_d = R_BEATS; else r_state_d = R_IDLE;
            R_BEATS: if (r_hs_s && r_last_q) r_state_d = R_IDLE; else r_state_d = R_BEATS;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read outputs; cnt holds beats remaining after the current one.
    always_comb begin
        if (ar_hs_s) begin
            cnt_d    = ar_len_i;
            r_id_d   = ar_id_i;
            r_resp_d = err_resp(ar_addr_i);
        end else if (r_hs_s) begin
            cnt_d    = cnt_q - 8'd1;
            r_id_d   = r_id_q;
            r_resp_d = r_resp_q;
        end else begin
            cnt_d    = cnt_q;
            r_id_d   = r_id_q;
            r_resp_d = r_resp_q;
        end
        ar_ready_d = (r_state_d == R_IDLE);
        r_valid_d  = (r_state_d == R_BEATS);
        r_last_d   = (r_state_d == R_BEATS) && (cnt_d == 8'd0);
    end

    // Read output registers; all deasserted while in reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= {IdWidth{1'b0}};
            r_resp_q   <= 2'b00;
            cnt_q      <= 8'd0;
        end else begin
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            r_resp_q   <= r_resp_d;
            cnt_q      <= cnt_d;
        end
    end

    assign aw_ready_o = aw_ready_q;
    assign w_ready_o  = w_ready_q;
    assign b_valid_o  = b_valid_q;
    assign b_id_o     = b_id_q;
    assign b_resp_o   = b_resp_q;
    assign ar_ready_o = ar_ready_q;
    assign r_valid_o  = r_valid_q;
    assign r_last_o   = r_last_q;
    assign r_id_o     = r_id_q;
    assign r_resp_o   = r_resp_q;
    assign r_data_o   = {DataWidth{1'b0}};

endmodule

// File: tb/tb_carfield_region_err_slv.sv
// Randomised + directed bench for carfield_region_err_slv against a
// transaction-level reference model.
module tb_carfield_region_err_slv;

    localparam logic [63:0] TB_BASE [8] = '{
        64'h7800_0000, 64'h7820_0000, 64'h6000_0000, 64'h2000_0000,
        64'h2000_1000, 64'h5100_0000, 64'h5000_0000, 64'h4000_0000};
    localparam logic [63:0] TB_SIZE [8] = '{
        64'h20_0000, 64'h20_0000, 64'h80_0000, 64'h1000,
        64'h9000,    64'h80_0000, 64'h80_0000, 64'h1000};
    localparam logic [7:0] TB_EN = 8'b1001_0011;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [63:0] dec_addr_i;
    logic [2:0]  dec_idx_o;
    logic        dec_hit_o;
    logic        aw_valid_i, aw_ready_o;
    logic [63:0] aw_addr_i;
    logic [7:0]  aw_len_i;
    logic [3:0]  aw_id_i;
    logic        w_valid_i, w_ready_o, w_last_i;
    logic        b_valid_o, b_ready_i;
    logic [1:0]  b_resp_o;
    logic [3:0]  b_id_o;
    logic        ar_valid_i, ar_ready_o;
    logic [63:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic [3:0]  ar_id_i;
    logic        r_valid_o, r_ready_i;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;
    logic [3:0]  r_id_o;

    always #5 clk = ~clk;

    carfield_region_err_slv dut (
        .clk_i(clk), .rst_i(rst_i),
        .dec_addr_i(dec_addr_i), .dec_idx_o(dec_idx_o), .dec_hit_o(dec_hit_o),
        .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_addr_i(aw_addr_i),
        .aw_len_i(aw_len_i), .aw_id_i(aw_id_i),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_last_i(w_last_i),
        .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_resp_o(b_resp_o), .b_id_o(b_id_o),
        .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_addr_i(ar_addr_i),
        .ar_len_i(ar_len_i), .ar_id_i(ar_id_i),
        .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_data_o(r_data_o),
        .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_id_o(r_id_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (transaction level)
    bit         alive;
    bit         w_pend, w_done;
    logic [3:0] m_w_id;
    logic [1:0] m_w_resp;
    int         w_beats, b_count;
    bit         r_pend;
    int         r_left, r_beats, r_count;
    logic [3:0] m_r_id;
    logic [1:0] m_r_resp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit in_reg(input logic [63:0] a, input int i);
        return (a >= TB_BASE[i]) && ((a - TB_BASE[i]) < TB_SIZE[i]);
    endfunction

    function automatic void ref_decode(input logic [63:0] a, output logic hit, output logic [2:0] idx);
        hit = 1'b0;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!hit && TB_EN[i] && in_reg(a, i)) begin
                hit = 1'b1;
                idx = i[2:0];
            end
        end
    endfunction

    function automatic logic [1:0] ref_resp(input logic [63:0] a);
        for (int i = 0; i < 8; i++) begin
            if (!TB_EN[i] && in_reg(a, i)) return 2'b10;
        end
        return 2'b11;
    endfunction

    function automatic logic [63:0] pick_addr();
        int r;
        int k;
        r = $urandom_range(0, 5);
        k = $urandom_range(0, 7);
        case (r)
            0: return TB_BASE[k];
            1: return TB_BASE[k] - 64'd1;
            2: return TB_BASE[k] + TB_SIZE[k] - 64'd1;
            3: return TB_BASE[k] + TB_SIZE[k];
            4: return {32'h0, 32'($urandom)};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    task automatic model_clear();
        alive = 1'b0;
        w_pend = 1'b0;
        w_done = 1'b0;
        r_pend = 1'b0;
        r_left = 0;
    endtask

    // Every-cycle comparison of all DUT outputs against the model.
    task automatic compare();
        logic       e_hit;
        logic [2:0] e_idx;
        ref_decode(dec_addr_i, e_hit, e_idx);
        chk("dec_hit", dec_hit_o, e_hit);
        chk("dec_idx", dec_idx_o, e_idx);
        chk("aw_ready", aw_ready_o, alive && !w_pend);
        chk("w_ready", w_ready_o, w_pend && !w_done);
        chk("b_valid", b_valid_o, w_pend && w_done);
        if (w_pend && w_done) begin
            chk("b_id", b_id_o, m_w_id);
            chk("b_resp", b_resp_o, m_w_resp);
        end
        chk("ar_ready", ar_ready_o, alive && !r_pend);
        chk("r_valid", r_valid_o, r_pend);
        if (r_pend) begin
            chk("r_last", r_last_o, r_left == 1);
            chk("r_data", r_data_o, 64'h0);
            chk("r_id", r_id_o, m_r_id);
            chk("r_resp", r_resp_o, m_r_resp);
        end
    endtask

    // One clock: advance the model on the edge, then compare.
    task automatic step();
        bit aw_hs, w_hs, b_hs, ar_hs, r_hs;
        @(posedge clk);
        if (rst_i) begin
            model_clear();
        end else begin
            aw_hs = alive && !w_pend && aw_valid_i;
            w_hs  = w_pend && !w_done && w_valid_i;
            b_hs  = w_pend && w_done && b_ready_i;
            ar_hs = alive && !r_pend && ar_valid_i;
            r_hs  = r_pend && r_ready_i;
            if (b_hs) begin
                w_pend = 1'b0;
                b_count++;
            end
            if (w_hs) begin
                w_beats++;
                if (w_last_i) w_done = 1'b1;
            end
            if (aw_hs) begin
                w_pend = 1'b1;
                w_done = 1'b0;
                m_w_id = aw_id_i;
                m_w_resp = ref_resp(aw_addr_i);
                w_beats = 0;
            end
            if (r_hs) begin
                r_left--;
                r_beats++;
                if (r_left == 0) begin
                    r_pend = 1'b0;
                    r_count++;
                end
            end
            if (ar_hs) begin
                r_pend = 1'b1;
                r_left = int'(ar_len_i) + 1;
                r_beats = 0;
                m_r_id = ar_id_i;
                m_r_resp = ref_resp(ar_addr_i);
            end
            alive = 1'b1;
        end
        #1;
        compare();
    endtask

    task automatic idle_inputs();
        aw_valid_i = 1'b0; w_valid_i = 1'b0; w_last_i = 1'b0; b_ready_i = 1'b0;
        ar_valid_i = 1'b0; r_ready_i = 1'b0;
    endtask

    // Asynchronous reset mid-cycle, held two edges, released on a falling edge.
    task automatic do_reset();
        rst_i = 1'b1;
        model_clear();
        #1;
        chk("rst_aw_ready", aw_ready_o, 1'b0);
        chk("rst_w_ready", w_ready_o, 1'b0);
        chk("rst_b_valid", b_valid_o, 1'b0);
        chk("rst_ar_ready", ar_ready_o, 1'b0);
        chk("rst_r_valid", r_valid_o, 1'b0);
        chk("rst_r_last", r_last_o, 1'b0);
        chk("rst_b_id_resp", {b_id_o, b_resp_o}, 6'h0);
        chk("rst_r_id_resp", {r_id_o, r_resp_o}, 6'h0);
        step();
        step();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        int bc;
        bit done;
        rst_i = 1'b1;
        dec_addr_i = 64'h0; aw_addr_i = 64'h0; ar_addr_i = 64'h0;
        aw_len_i = 8'd0; ar_len_i = 8'd0; aw_id_i = 4'd0; ar_id_i = 4'd0;
        idle_inputs();
        b_count = 0; r_count = 0; w_beats = 0; r_beats = 0;
        model_clear();
        step();
        do_reset();
        step();
        chk("ready_after_release_aw", aw_ready_o, 1'b1);
        chk("ready_after_release_ar", ar_ready_o, 1'b1);

        // Decoder literals
        dec_addr_i = 64'h7820_0010; #1;
        chk("dec_l2p1_hit", dec_hit_o, 1'b1);
        chk("dec_l2p1_idx", dec_idx_o, 3'd1);
        dec_addr_i = 64'h781F_FFFF; #1;
        chk("dec_l2p0_idx", dec_idx_o, 3'd0);
        chk("dec_l2p0_hit", dec_hit_o, 1'b1);
        dec_addr_i = 64'h7840_0000; #1;
        chk("dec_past_end_hit", dec_hit_o, 1'b0);
        dec_addr_i = 64'h2000_1000; #1;
        chk("dec_periph_idx", dec_idx_o, 3'd4);
        dec_addr_i = 64'h2000_0FFF; #1;
        chk("dec_disabled_hit", dec_hit_o, 1'b0);

        // Write to disabled SafetyIsland: 4 beats, SLVERR
        aw_valid_i = 1'b1; aw_addr_i = 64'h6000_0000; aw_len_i = 8'd3; aw_id_i = 4'd5;
        step();
        aw_valid_i = 1'b0;
        w_valid_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w_last_i = (k == 3);
            step();
        end
        w_valid_i = 1'b0; w_last_i = 1'b0;
        chk("wr_beats", w_beats, 4);
        chk("wr_b_valid", b_valid_o, 1'b1);
        chk("wr_b_resp", b_resp_o, 2'b10);
        chk("wr_b_id", b_id_o, 4'd5);
        bc = b_count;
        b_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;
        chk("wr_b_done", b_count, bc + 1);

        // Single-beat read to unmapped space: DECERR
        ar_valid_i = 1'b1; ar_addr_i = 64'h1000_0000; ar_len_i = 8'd0; ar_id_i = 4'd2;
        step();
        ar_valid_i = 1'b0;
        chk("rd0_valid", r_valid_o, 1'b1);
        chk("rd0_last", r_last_o, 1'b1);
        chk("rd0_data", r_data_o, 64'h0);
        chk("rd0_resp", r_resp_o, 2'b11);
        chk("rd0_id", r_id_o, 4'd2);
        r_ready_i = 1'b1;
        step();
        r_ready_i = 1'b0;
        chk("rd0_done", r_valid_o, 1'b0);

        // 256-beat read with r_ready toggling
        ar_valid_i = 1'b1; ar_addr_i = 64'h5000_0040; ar_len_i = 8'd255; ar_id_i = 4'd9;
        step();
        ar_valid_i = 1'b0;
        bc = r_count;
        done = 1'b0;
        for (int k = 0; k < 1000 && !done; k++) begin
            r_ready_i = k[0];
            step();
            done = (r_count != bc);
        end
        r_ready_i = 1'b0;
        chk("rd256_finished", done, 1'b1);
        chk("rd256_beats", r_beats, 256);

        // B stalled 10 cycles with a new AW pending
        aw_valid_i = 1'b1; aw_addr_i = 64'h4000_0000; aw_id_i = 4'd7;
        step();
        w_valid_i = 1'b1; w_last_i = 1'b1; aw_addr_i = 64'h2000_0000; aw_id_i = 4'd3;
        step();
        w_valid_i = 1'b0; w_last_i = 1'b0;
        for (int k = 0; k < 10; k++) step();
        chk("bstall_b_valid", b_valid_o, 1'b1);
        chk("bstall_aw_ready", aw_ready_o, 1'b0);
        chk("bstall_b_resp", b_resp_o, 2'b11);
        b_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;
        chk("bstall_aw_ready_after", aw_ready_o, 1'b1);
        step();
        aw_valid_i = 1'b0;
        chk("bstall_new_aw_taken", w_ready_o, 1'b1);
        w_valid_i = 1'b1; w_last_i = 1'b1;
        step();
        w_valid_i = 1'b0; w_last_i = 1'b0;
        chk("bstall_second_resp", b_resp_o, 2'b10);
        b_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;

        // Reset while in the data phase after 2 of 4 beats
        aw_valid_i = 1'b1; aw_addr_i = 64'h6000_0100; aw_id_i = 4'd1;
        step();
        aw_valid_i = 1'b0;
        w_valid_i = 1'b1;
        step();
        step();
        w_valid_i = 1'b0;
        bc = b_count;
        do_reset();
        b_ready_i = 1'b1;
        step();
        chk("midrst_aw_ready", aw_ready_o, 1'b1);
        for (int k = 0; k < 5; k++) step();
        chk("midrst_no_b", b_valid_o, 1'b0);
        chk("midrst_b_count", b_count, bc);
        idle_inputs();

        // Randomised traffic
        for (int n = 0; n < 4000; n++) begin
            aw_valid_i = ($urandom_range(0, 2) == 0);
            aw_addr_i  = pick_addr();
            aw_len_i   = 8'($urandom);
            aw_id_i    = 4'($urandom);
            w_valid_i  = ($urandom_range(0, 1) == 0);
            w_last_i   = ($urandom_range(0, 3) == 0);
            b_ready_i  = ($urandom_range(0, 1) == 0);
            ar_valid_i = ($urandom_range(0, 2) == 0);
            ar_addr_i  = pick_addr();
            ar_len_i   = 8'($urandom_range(0, 15));
            ar_id_i    = 4'($urandom);
            r_ready_i  = ($urandom_range(0, 1) == 0);
            dec_addr_i = pick_addr();
            if ($urandom_range(0, 599) == 0) do_reset();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
